ffe_tdm_mac: RTL and testbench

- Parametrised successor to the fixed 12-bit FFE: a TAPS-tap feed-forward equaliser with runtime-programmable coefficients.
- Uses one time-multiplexed multiply-accumulate unit, stepping through one tap per ffe_clk cycle.
- Replaces the separate data clock with a load/in_ready handshake in a single clock domain.
- Sits between the sample source and the slicer; produces one rounded, saturated output per accepted sample.

---
 rtl/ffe_tdm_mac.sv | 200 ++++++++++++++++++++
 tb/tb_ffe_tdm_mac.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ffe_tdm_mac.sv
// ffe_tdm_mac: TAPS-tap feed-forward equaliser built around one time-multiplexed
// multiply-accumulate unit. A sample is accepted with a load/in_ready handshake.
// The MAC then walks the taps one per clock. Each accepted sample produces one
// rounded, saturated result, which is flagged by a single-cycle y_valid pulse.
// Optional feature: define FFE_SAT_CNT_EN to add the sat_cnt port. It is an
// 8-bit sticky count of results that were clamped by the saturation stage.
module ffe_tdm_mac #(
  parameter int DATA_W    = 12,
  parameter int COEF_W    = 12,
  parameter int FRAC_BITS = 10,
  parameter int TAPS      = 4,
  parameter int ADDR_W    = $clog2(TAPS)
) (
  input  logic                     ffe_clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] d_in,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic        [ADDR_W-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] y,
  output logic                     y_valid
`ifdef FFE_SAT_CNT_EN
  ,
  output logic               [7:0] sat_cnt
`endif
);

  // Product width. The accumulator adds guard bits so a full sum of TAPS
  // products can never wrap.
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  // The rounding adder carries one extra bit above the accumulator.
  localparam int RW     = ACC_W + 1;

  localparam logic signed [COEF_W-1:0] C_ONE    = COEF_W'(2 ** FRAC_BITS);
  localparam logic signed [RW-1:0]     RND_HALF = RW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [RW-1:0]     Y_MAX    = RW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [RW-1:0]     Y_MIN    = ~Y_MAX;
  localparam logic        [ADDR_W-1:0] IDX_LAST = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_coef_wr;
  logic                       w_last_tap;

  logic signed [DATA_W-1:0]   r_x [TAPS];
  logic signed [COEF_W-1:0]   r_c [TAPS];
  logic signed [ACC_W-1:0]    r_acc;
  logic        [ADDR_W-1:0]   r_idx;
  logic signed [DATA_W-1:0]   r_y;
  logic                       r_y_valid;

  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [RW-1:0]       w_rnd;
  logic signed [RW-1:0]       w_shr;
  logic signed [DATA_W-1:0]   w_sat;

  // Handshake qualifiers. Both writes are only honoured while idle.
  assign w_accept   = w_in_ready && load;
  // The address is widened to 32 bits so the range test is meaningful for any TAPS.
  assign w_coef_wr  = w_in_ready && coef_we &&
                      ({{(32 - ADDR_W){1'b0}}, coef_addr} < 32'(TAPS));
  assign w_last_tap = (r_idx == IDX_LAST);

  // State register.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state always uses non-blocking assignment, so that every
      // register samples the values from before the edge.
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and ready flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so an unlisted
    // path can never infer a latch.
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (load) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (w_last_tap) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready = w_in_ready;

  // Delay line shift and coefficient write. Reset gives zero history and pass-through taps.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these small register arrays are reset on purpose, because the
      // cleared history and the pass-through taps are visible behaviour. Large
      // data RAMs would normally be left unreset.
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_c[i] <= (i == 0) ? C_ONE : '0;
      end
    end else begin
      if (w_accept) begin
        r_x[0] <= d_in;
        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
      end
      if (w_coef_wr) r_c[coef_addr] <= coef_data;
    end
  end

  // One tap per cycle: sign-extended product added into the accumulator.
  assign w_prod     = PROD_W'(r_x[r_idx]) * PROD_W'(r_c[r_idx]);
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Accumulator and tap index.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (!w_last_tap) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Round half toward +inf, then clamp to the signed output range.
  assign w_rnd = $signed({r_acc[ACC_W-1], r_acc}) + RND_HALF;
  assign w_shr = w_rnd >>> FRAC_BITS;

  // Saturation select.
  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > Y_MAX)      w_sat = Y_MAX[DATA_W-1:0];
    else if (w_shr < Y_MIN) w_sat = Y_MIN[DATA_W-1:0];
  end

  // Output register. y holds until the next result, and y_valid pulses for one cycle.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= (r_state == S_OUT);
      if (r_state == S_OUT) r_y <= w_sat;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;

`ifdef FFE_SAT_CNT_EN
  logic       w_clamp;
  logic [7:0] r_sat_cnt;

  assign w_clamp = (w_shr > Y_MAX) || (w_shr < Y_MIN);

  // Sticky count of clamped results. It updates on the same edge as y_valid.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      r_sat_cnt <= '0;
    end else if ((r_state == S_OUT) && w_clamp && (r_sat_cnt != 8'hFF)) begin
      r_sat_cnt <= r_sat_cnt + 8'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_ffe_tdm_mac.sv
// Scoreboard bench for ffe_tdm_mac (DATA_W=12, COEF_W=12, FRAC_BITS=10, TAPS=4).
// The driver pushes hand-computed results and their due cycle. The monitor pops
// and compares them whenever y_valid is seen.
module tb_ffe_tdm_mac;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load;
  logic signed [11:0] d_in;
  logic               in_ready;
  logic               coef_we;
  logic        [1:0]  coef_addr;
  logic signed [11:0] coef_data;
  logic signed [11:0] y;
  logic               y_valid;
`ifdef FFE_SAT_CNT_EN
  logic        [7:0]  sat_cnt;
`endif

  ffe_tdm_mac #(
    .DATA_W(12), .COEF_W(12), .FRAC_BITS(10), .TAPS(4)
  ) dut (
    .ffe_clk   (clk),
    .rst       (rst_n),
    .load      (load),
    .d_in      (d_in),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y         (y),
    .y_valid   (y_valid)
`ifdef FFE_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [11:0] y;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_valid = 1'b0;
    end else begin
      if (y_valid) begin
        check("y_valid_single_cycle", prev_valid, 0);
        if (sb.size() == 0) begin
          check("unexpected_y_valid", y_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("y_value", y, mon_e.y);
          check("y_latency", cyc, mon_e.cyc);
        end
      end
      prev_valid = y_valid;
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    load      = 1'b0;
    d_in      = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic write_coef(input logic [1:0] addr, input logic signed [11:0] val);
    @(negedge clk);
    wait_ready();
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = val;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  // Accepted on the next edge; the result is due 5 edges later.
  task automatic send(input logic signed [11:0] v, input bit push,
                      input logic signed [11:0] exp_y);
    @(negedge clk);
    wait_ready();
    load = 1'b1;
    d_in = v;
    @(posedge clk);
    #1;
    load = 1'b0;
    d_in = '0;
    if (push) sb.push_back('{y: exp_y, cyc: cyc + 5});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    d_in      = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    // 1: pass-through after reset, latency and busy window
    do_reset();
    check("reset_y", y, 0);
    check("reset_y_valid", y_valid, 0);
    check("reset_in_ready", in_ready, 1);
    send(12'sd10, 1'b1, 12'sd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_in_ready", in_ready, 0);
    end
    @(negedge clk);
    check("ready_with_y_valid", in_ready, 1);
    check("y_valid_at_out", y_valid, 1);
    wait_idle();

    // 2: c0=0.5, c1=0.25; 100 -> 50, 200 -> 125, then y holds
    do_reset();
    write_coef(2'd0, 12'sd512);
    write_coef(2'd1, 12'sd256);
    send(12'sd100, 1'b1, 12'sd50);
    send(12'sd200, 1'b1, 12'sd125);
    wait_idle();
    repeat (3) @(negedge clk);
    check("y_hold", y, 125);

    // 3: saturation at both rails
    do_reset();
    write_coef(2'd0, 12'sd2047);
    send(12'sd2047, 1'b1, 12'sd2047);
    send(-12'sd2048, 1'b1, -12'sd2048);
    wait_idle();
`ifdef FFE_SAT_CNT_EN
    check("sat_cnt", sat_cnt, 2);
`endif

    // 4: round half toward +inf
    do_reset();
    write_coef(2'd0, 12'sd512);
    send(12'sd3, 1'b1, 12'sd2);
    send(-12'sd3, 1'b1, -12'sd1);
    wait_idle();

    // 5: load and coef_we while busy are both ignored
    do_reset();
    send(12'sd7, 1'b1, 12'sd7);
    @(negedge clk);
    load      = 1'b1;
    d_in      = 12'sd99;
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 12'sd0;
    @(posedge clk);
    #1;
    load    = 1'b0;
    d_in    = '0;
    coef_we = 1'b0;
    check("busy_ignore_in_ready", in_ready, 0);
    wait_idle();
    send(12'sd5, 1'b1, 12'sd5);
    wait_idle();

    // 6: reset during MAC cycle 2 aborts; coefficients and history are restored
    write_coef(2'd1, 12'sd1024);
    send(12'sd20, 1'b0, 12'sd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_y", y, 0);
    check("abort_y_valid", y_valid, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(12'sd10, 1'b1, 12'sd10);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
